alu_arbiter: RTL and testbench

Shares the single miniRISC `alu` between two requesters: requester 0 is the execute stage and requester 1 is the branch/address-generation unit. Each requester issues a registered valid/ready operation. The arbiter grants one requester, latches its operands into the ALU, and captures `result`/`carry`. It returns the response tagged with the requester id and holds it until the requester accepts it. At most one operation is in flight.

---
 rtl/minirisc_pkg.sv | 22 ++
 rtl/alu.sv | 49 ++++
 rtl/alu_arb_grant.sv | 27 ++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/minirisc_pkg.sv
// Shared miniRISC types and constants: arbiter FSM states, ALU opcodes, requester ids.
package minirisc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } alu_arb_state_t;

    localparam logic [4:0] ALU_OP_ADD   = 5'd0;
    localparam logic [4:0] ALU_OP_SUB   = 5'd1;
    localparam logic [4:0] ALU_OP_AND   = 5'd2;
    localparam logic [4:0] ALU_OP_OR    = 5'd3;
    localparam logic [4:0] ALU_OP_XOR   = 5'd4;
    localparam logic [4:0] ALU_OP_SLL   = 5'd5;
    localparam logic [4:0] ALU_OP_SRL   = 5'd6;
    localparam logic [4:0] ALU_OP_PASSB = 5'd7;

    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_AGU  = 1'b1;

endpackage

// File: rtl/alu.sv
// miniRISC ALU. ALUipsel = 1 swaps the A/B operands before the operation.
// carry is the adder carry-out for ADD and the no-borrow flag for SUB; 0 otherwise.
module alu
    import minirisc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ALUipsel,
    input  logic [OPW-1:0]   ALUopsel,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] x, y;
    logic [WIDTH:0]   sum;

    always_comb begin
        x      = ALUipsel ? b : a;
        y      = ALUipsel ? a : b;
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (ALUopsel)
            ALU_OP_ADD: begin
                sum    = {1'b0, x} + {1'b0, y};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_OP_SUB: begin
                sum    = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            ALU_OP_AND:   result = x & y;
            ALU_OP_OR:    result = x | y;
            ALU_OP_XOR:   result = x ^ y;
            ALU_OP_SLL:   result = x << y[SHW-1:0];
            ALU_OP_SRL:   result = x >> y[SHW-1:0];
            ALU_OP_PASSB: result = y;
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_grant.sv
// One-hot grant for the two ALU requesters.
// ALU_ARB_RR_EN selects round-robin (pointer = preferred requester); otherwise fixed priority.
module alu_arb_grant (
    input  logic [1:0] req_valid,
    input  logic       pointer,
    output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_pointer;
    assign unused_pointer = pointer;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0];
        grant[1] = req_valid[1] & ~req_valid[0];
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (id 0) and the AGU (id 1); one op in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
    import minirisc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req0_ipsel,
    input  logic             req1_ipsel,
    input  logic [OPW-1:0]   req0_opsel,
    input  logic [OPW-1:0]   req1_opsel,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    input  logic             rsp_ready,
    output logic             busy
);

    alu_arb_state_t   state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             ipsel_q;
    logic [OPW-1:0]   opsel_q;
    logic             id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;

    logic [1:0]       grant;
    logic             pointer;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    alu_arb_grant u_grant (
        .req_valid (req_valid),
        .pointer   (pointer),
        .grant     (grant)
    );

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a        (op_a_q),
        .b        (op_b_q),
        .ALUipsel (ipsel_q),
        .ALUopsel (opsel_q),
        .result   (alu_result),
        .carry    (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        // Ready is also forced low while reset is held, so no accept is advertised.
        req_ready = (state_q == StIdle && rst_n) ? grant : 2'b00;
        accept    = 1'b0;
        sel       = grant[1];
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ALU_ARB_RR_EN
    logic ptr_q;

    // After a grant, prefer the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_EXEC;
        end else if (accept) begin
            ptr_q <= ~sel;
        end
    end

    assign pointer = ptr_q;
`else
    assign pointer = REQ_EXEC;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_a_q       <= '0;
            op_b_q       <= '0;
            ipsel_q      <= 1'b0;
            opsel_q      <= '0;
            id_q         <= REQ_EXEC;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q  <= sel ? req1_a : req0_a;
                op_b_q  <= sel ? req1_b : req0_b;
                ipsel_q <= sel ? req1_ipsel : req0_ipsel;
                opsel_q <= sel ? req1_opsel : req0_opsel;
                id_q    <= sel;
            end
            if (state_q == StExec) begin
                rsp_result_q <= alu_result;
                rsp_carry_q  <= alu_carry;
            end
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic
// checked against a transaction-level model of the ALU and arbitration policy.
module tb_alu_arbiter;
    import minirisc_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ipsel, req1_ipsel;
    logic [4:0]   req0_opsel, req1_opsel;
    logic         rsp_valid, rsp_id, rsp_carry, rsp_ready, busy;
    logic [W-1:0] rsp_result;

    int checks = 0;
    int errors = 0;
    logic pref = 1'b0;

    alu_arbiter #(.WIDTH(W), .OPW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ipsel (req0_ipsel),
        .req1_ipsel (req1_ipsel),
        .req0_opsel (req0_opsel),
        .req1_opsel (req1_opsel),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: {carry, result} from plain arithmetic.
    function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ip, input logic [4:0] op);
        logic [W-1:0] x, y;
        x = ip ? b : a;
        y = ip ? a : b;
        case (op)
            ALU_OP_ADD:   return {1'b0, x} + {1'b0, y};
            ALU_OP_SUB:   return {(x >= y), x - y};
            ALU_OP_AND:   return {1'b0, x & y};
            ALU_OP_OR:    return {1'b0, x | y};
            ALU_OP_XOR:   return {1'b0, x ^ y};
            ALU_OP_SLL:   return {1'b0, x << (y % 32)};
            ALU_OP_SRL:   return {1'b0, x >> (y % 32)};
            ALU_OP_PASSB: return {1'b0, y};
            default:      return '0;
        endcase
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return pref ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    task automatic randomize_ops();
        req0_a     = $urandom;
        req0_b     = $urandom;
        req1_a     = $urandom;
        req1_b     = $urandom;
        req0_ipsel = 1'($urandom_range(0, 1));
        req1_ipsel = 1'($urandom_range(0, 1));
        req0_opsel = 5'($urandom_range(0, 8));
        req1_opsel = 5'($urandom_range(0, 8));
    endtask

    // Present a request from IDLE, accept it and stop in RESP; operands are
    // scrambled after the accept so the response must come from latched values.
    task automatic issue(input logic [1:0] v, input logic hold, output logic g,
                         output logic [W:0] e);
        logic [1:0] eg;
        eg = exp_grant(v);
        req_valid = v;
        #1;
        check("req_ready_idle", req_ready, eg);
        g = eg[1];
        e = g ? ref_alu(req1_a, req1_b, req1_ipsel, req1_opsel)
              : ref_alu(req0_a, req0_b, req0_ipsel, req0_opsel);
        tick();
        pref = ~g;
        if (!hold) req_valid = 2'b00;
        randomize_ops();
        #1;
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_req_ready", req_ready, 0);
        tick();
        check("resp_valid", rsp_valid, 1);
        check("resp_id", rsp_id, g);
        check("resp_result", rsp_result, e[W-1:0]);
        check("resp_carry", rsp_carry, e[W]);
        check("resp_req_ready", req_ready, 0);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        #1;
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        logic       g;
        logic [W:0] e;
        logic [1:0] v;
        int         bp;

        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        randomize_ops();
        tick();
        tick();
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_carry", rsp_carry, 0);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        tick();

        // Reset while in EXEC drops the operation.
        req1_a = 32'h1234; req1_b = 32'h1; req1_opsel = ALU_OP_ADD; req1_ipsel = 1'b0;
        req_valid = 2'b10;
        #1;
        check("rst_exec_ready", req_ready, 2'b10);
        tick();
        check("rst_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_result", rsp_result, 0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        pref      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_rsp", rsp_valid, 0);
        end

        // Single request: 3 + 7.
        req0_a = 32'd3; req0_b = 32'd7; req0_ipsel = 1'b0; req0_opsel = ALU_OP_ADD;
        issue(2'b01, 1'b0, g, e);
        check("single_id", rsp_id, REQ_EXEC);
        check("single_result", rsp_result, 32'd10);
        check("single_carry", rsp_carry, 0);
        release_rsp();

        // Carry out of the adder from the AGU.
        req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ipsel = 1'b0; req1_opsel = ALU_OP_ADD;
        issue(2'b10, 1'b0, g, e);
        check("carry_id", rsp_id, REQ_AGU);
        check("carry_result", rsp_result, 32'd0);
        check("carry_carry", rsp_carry, 1);
        release_rsp();

        // Contention with rsp_ready tied high: one op every 3 cycles.
        for (int k = 0; k < 6; k++) begin
            randomize_ops();
            issue(2'b11, 1'b1, g, e);
`ifdef ALU_ARB_RR_EN
            check("contend_grant", g, k % 2);
`else
            check("contend_grant", g, 0);
`endif
            rsp_ready = 1'b1;
            tick();
            check("contend_idle", busy, 0);
        end
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        tick();

        // Backpressure: response held for 5 cycles, no ready while in RESP.
        randomize_ops();
        issue(2'b11, 1'b1, g, e);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, e[W-1:0]);
            check("bp_carry", rsp_carry, e[W]);
            check("bp_id", rsp_id, g);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("bp_idle_busy", busy, 0);
        check("bp_idle_ready", req_ready, exp_grant(2'b11));
        g = exp_grant(2'b11) == 2'b10;
        tick();
        pref = ~g;
        check("bp_reaccept_busy", busy, 1);
        req_valid = 2'b00;
        tick();
        check("bp_reaccept_rsp", rsp_valid, 1);
        check("bp_reaccept_id", rsp_id, g);
        release_rsp();

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            randomize_ops();
            v = 2'($urandom_range(0, 3));
            if (v == 2'b00) begin
                req_valid = 2'b00;
                #1;
                check("rand_no_ready", req_ready, 0);
                tick();
                check("rand_no_busy", busy, 0);
            end else begin
                issue(v, 1'($urandom_range(0, 1)), g, e);
                bp = $urandom_range(0, 3);
                for (int i = 0; i < bp; i++) begin
                    tick();
                    check("rand_hold_result", rsp_result, e[W-1:0]);
                    check("rand_hold_valid", rsp_valid, 1);
                end
                release_rsp();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
